// File: rtl/vote_bram_reader_pkg.sv
// Shared definitions for the vote BRAM reader: FSM state encoding, default
// widths and the field layout of a vote word.
//   Vote word: [DATA_W-1] valid flag, [CLS_LSB +: CLS_W] class index,
//   every other bit is ignored.
package vote_bram_reader_pkg;

    localparam int DEF_ADDR_W  = 14;
    localparam int DEF_DATA_W  = 38;
    localparam int DEF_N_CLASS = 8;
    localparam int DEF_RD_LAT  = 1;

    // Class index sits at the bottom of the word.
    localparam int CLS_LSB = 0;

    // The valid flag is always the top bit, so its position depends on width.
    function automatic int valid_bit(input int data_w);
        return data_w - 1;
    endfunction

    localparam int VALID_BIT = valid_bit(DEF_DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_ARGMAX = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_OUT    = 3'd5
    } state_e;

endpackage

// File: rtl/vote_bram_reader_tally.sv
// vote_tally: per-class vote counters plus a sequential argmax scanner.
//   clk_i/rst_i   clock, synchronous active-high reset
//   clr_i         zero counters and the running best (start of a new tally)
//   vote_en_i     increment counter[vote_cls_i] this cycle
//   scan_i        argmax step: compare one class per cycle, index auto-advances
//   scan_done_o   high on the step that examines the last class
//   best_cls_o / best_votes_o   running winner (final once the scan is done)
module vote_tally
    import vote_bram_reader_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int N_CLASS = DEF_N_CLASS
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       vote_en_i,
    input  logic [$clog2(N_CLASS)-1:0] vote_cls_i,
    input  logic                       scan_i,
    output logic                       scan_done_o,
    output logic [$clog2(N_CLASS)-1:0] best_cls_o,
    output logic [ADDR_W-1:0]          best_votes_o
);

    localparam int CLS_W = $clog2(N_CLASS);

    logic [ADDR_W-1:0] cnt_q [N_CLASS];
    logic [CLS_W-1:0]  scan_idx_q;
    logic [CLS_W-1:0]  best_cls_q;
    logic [ADDR_W-1:0] best_votes_q;

    assign scan_done_o  = scan_i & (scan_idx_q == CLS_W'(N_CLASS - 1));
    assign best_cls_o   = best_cls_q;
    assign best_votes_o = best_votes_q;

    // Counter bank and argmax scan state.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            for (int k = 0; k < N_CLASS; k++) begin
                cnt_q[k] <= {ADDR_W{1'b0}};
            end
            scan_idx_q   <= {CLS_W{1'b0}};
            best_cls_q   <= {CLS_W{1'b0}};
            best_votes_q <= {ADDR_W{1'b0}};
        end else begin
            if (vote_en_i) begin
                cnt_q[vote_cls_i] <= cnt_q[vote_cls_i] + ADDR_W'(1);
            end
            if (scan_i) begin
                // Strictly greater only: equal counts keep the lower index.
                if (cnt_q[scan_idx_q] > best_votes_q) begin
                    best_cls_q   <= scan_idx_q;
                    best_votes_q <= cnt_q[scan_idx_q];
                end
                // Wraps back to 0 after the last class, ready for the next tally.
                scan_idx_q <= scan_idx_q + CLS_W'(1);
            end
        end
    end

endmodule

// File: rtl/vote_bram_reader.sv
// vote_bram_reader: reads a range of vote words from BRAM port B, tallies the
// valid votes per class, picks the winning class, optionally zeroes the range,
// then presents the result on a valid/ready handshake.
//   bram_clkb_i / bram_rstb_i     clock, synchronous active-high reset
//   start_i, base_addr_i, num_trees_i   tally request (ignored while busy_o)
//   busy_o                        request accepted and result not yet taken
//   bram_enb_o/web_o/addrb_o/dinb_o/doutb_i   BRAM port B
//   result_class_o/votes_o/valid_o, result_ready_i   result handshake
module vote_bram_reader
    import vote_bram_reader_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int N_CLASS  = DEF_N_CLASS,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int CLEAR_EN = 1
) (
    input  logic                       bram_clkb_i,
    input  logic                       bram_rstb_i,
    input  logic                       start_i,
    input  logic [ADDR_W-1:0]          base_addr_i,
    input  logic [ADDR_W-1:0]          num_trees_i,
    output logic                       busy_o,
    output logic                       bram_enb_o,
    output logic                       bram_web_o,
    output logic [ADDR_W-1:0]          bram_addrb_o,
    output logic [DATA_W-1:0]          bram_dinb_o,
    input  logic [DATA_W-1:0]          bram_doutb_i,
    output logic [$clog2(N_CLASS)-1:0] result_class_o,
    output logic [ADDR_W-1:0]          result_votes_o,
    output logic                       result_valid_o,
    input  logic                       result_ready_i
);

    localparam int CLS_W = $clog2(N_CLASS);
    localparam int VB    = valid_bit(DATA_W);
    // All issue-tracker stages except the oldest; DRAIN may end once these are
    // empty because the oldest stage is captured on that same edge.
    localparam logic [RD_LAT-1:0] EARLY_MASK = RD_LAT'((1 << (RD_LAT - 1)) - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              enb_q, enb_d;
    logic              web_q, web_d;
    logic              busy_q;
    logic              valid_q;
    logic [RD_LAT-1:0] sr_q, sr_d;

    logic              clr_s;
    logic              rd_issue_s;
    logic              vote_en_s;
    logic              scan_s;
    logic              scan_done_s;
    logic [ADDR_W-1:0] last_s;
    logic              unused_s;

    assign rd_issue_s = enb_q & ~web_q;
    assign vote_en_s  = sr_q[RD_LAT-1] & bram_doutb_i[VB];
    assign scan_s     = (state_q == ST_ARGMAX);
    assign last_s     = num_q - ADDR_W'(1);
    assign unused_s   = ^bram_doutb_i[VB-1:CLS_LSB+CLS_W];

    assign busy_o         = busy_q;
    assign bram_enb_o     = enb_q;
    assign bram_web_o     = web_q;
    assign bram_addrb_o   = addr_q;
    assign bram_dinb_o    = {DATA_W{1'b0}};
    assign result_valid_o = valid_q;

    vote_tally #(
        .ADDR_W  (ADDR_W),
        .N_CLASS (N_CLASS)
    ) u_tally (
        .clk_i        (bram_clkb_i),
        .rst_i        (bram_rstb_i),
        .clr_i        (clr_s),
        .vote_en_i    (vote_en_s),
        .vote_cls_i   (bram_doutb_i[CLS_LSB +: CLS_W]),
        .scan_i       (scan_s),
        .scan_done_o  (scan_done_s),
        .best_cls_o   (result_class_o),
        .best_votes_o (result_votes_o)
    );

    // Next-state, address generation and BRAM port control.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        enb_d   = 1'b0;
        web_d   = 1'b0;
        clr_s   = 1'b0;
        // Shift a 1 in for every cycle the BRAM samples a read request.
        sr_d    = RD_LAT'({sr_q, rd_issue_s});
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d = base_addr_i;
                    num_d  = num_trees_i;
                    idx_d  = {ADDR_W{1'b0}};
                    clr_s  = 1'b1;
                    if (num_trees_i == {ADDR_W{1'b0}}) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_READ;
                        enb_d   = 1'b1;
                        addr_d  = base_addr_i;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (idx_q == last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    enb_d  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    idx_d  = idx_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if ((sr_q & EARLY_MASK) == {RD_LAT{1'b0}}) begin
                    state_d = ST_ARGMAX;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_ARGMAX: begin
                if (scan_done_s) begin
                    if (CLEAR_EN != 0) begin
                        state_d = ST_CLEAR;
                        enb_d   = 1'b1;
                        web_d   = 1'b1;
                        addr_d  = base_q;
                        idx_d   = {ADDR_W{1'b0}};
                    end else begin
                        state_d = ST_OUT;
                    end
                end else begin
                    state_d = ST_ARGMAX;
                end
            end
            ST_CLEAR: begin
                if (idx_q == last_s) begin
                    state_d = ST_OUT;
                end else begin
                    enb_d  = 1'b1;
                    web_d  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    idx_d  = idx_q + ADDR_W'(1);
                end
            end
            ST_OUT: begin
                if (result_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset also drops any reads in flight.
    always_ff @(posedge bram_clkb_i) begin
        if (bram_rstb_i) begin
            state_q <= ST_IDLE;
            base_q  <= {ADDR_W{1'b0}};
            num_q   <= {ADDR_W{1'b0}};
            idx_q   <= {ADDR_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            enb_q   <= 1'b0;
            web_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            sr_q    <= {RD_LAT{1'b0}};
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            enb_q   <= enb_d;
            web_q   <= web_d;
            busy_q  <= (state_d != ST_IDLE);
            valid_q <= (state_d == ST_OUT);
            sr_q    <= sr_d;
        end
    end

endmodule

// File: tb/tb_vote_bram_reader.sv
module tb_vote_bram_reader;

    localparam int AW = 14;
    localparam int DW = 38;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    int            sel;
    logic          start_s, ready_s;
    logic [AW-1:0] base_s, num_s;
    logic          tb_we;
    logic [AW-1:0] tb_waddr;
    logic [DW-1:0] tb_wdata;

    int checks = 0;
    int errors = 0;

    // DUT 1: RD_LAT = 1
    logic          start1, ready1, busy1, enb1, web1, valid1;
    logic [AW-1:0] addr1, votes1;
    logic [DW-1:0] din1, dout1;
    logic [2:0]    cls1;
    logic [DW-1:0] mem1 [0:(1<<AW)-1];

    // DUT 2: RD_LAT = 2
    logic          start2, ready2, busy2, enb2, web2, valid2;
    logic [AW-1:0] addr2, votes2;
    logic [DW-1:0] din2, dout2, d2a;
    logic [2:0]    cls2;
    logic [DW-1:0] mem2 [0:(1<<AW)-1];

    assign start1 = start_s & (sel == 1);
    assign start2 = start_s & (sel == 2);
    assign ready1 = ready_s & (sel == 1);
    assign ready2 = ready_s & (sel == 2);

    vote_bram_reader #(.RD_LAT(1)) dut1 (
        .bram_clkb_i(clk), .bram_rstb_i(rst), .start_i(start1),
        .base_addr_i(base_s), .num_trees_i(num_s), .busy_o(busy1),
        .bram_enb_o(enb1), .bram_web_o(web1), .bram_addrb_o(addr1),
        .bram_dinb_o(din1), .bram_doutb_i(dout1), .result_class_o(cls1),
        .result_votes_o(votes1), .result_valid_o(valid1), .result_ready_i(ready1)
    );

    vote_bram_reader #(.RD_LAT(2)) dut2 (
        .bram_clkb_i(clk), .bram_rstb_i(rst), .start_i(start2),
        .base_addr_i(base_s), .num_trees_i(num_s), .busy_o(busy2),
        .bram_enb_o(enb2), .bram_web_o(web2), .bram_addrb_o(addr2),
        .bram_dinb_o(din2), .bram_doutb_i(dout2), .result_class_o(cls2),
        .result_votes_o(votes2), .result_valid_o(valid2), .result_ready_i(ready2)
    );

    // BRAM model 1: one-cycle read-first
    always @(posedge clk) begin
        if (tb_we && sel == 1) mem1[tb_waddr] <= tb_wdata;
        else if (enb1 && web1) mem1[addr1] <= din1;
        if (enb1 && !web1) dout1 <= mem1[addr1];
    end

    // BRAM model 2: two-cycle read (extra output register)
    always @(posedge clk) begin
        if (tb_we && sel == 2) mem2[tb_waddr] <= tb_wdata;
        else if (enb2 && web2) mem2[addr2] <= din2;
        if (enb2 && !web2) d2a <= mem2[addr2];
        dout2 <= d2a;
    end

    logic          m_busy, m_enb, m_web, m_valid;
    logic [AW-1:0] m_addr, m_votes;
    logic [DW-1:0] m_din;
    logic [2:0]    m_cls;
    assign m_busy  = (sel == 2) ? busy2  : busy1;
    assign m_enb   = (sel == 2) ? enb2   : enb1;
    assign m_web   = (sel == 2) ? web2   : web1;
    assign m_valid = (sel == 2) ? valid2 : valid1;
    assign m_addr  = (sel == 2) ? addr2  : addr1;
    assign m_votes = (sel == 2) ? votes2 : votes1;
    assign m_din   = (sel == 2) ? din2   : din1;
    assign m_cls   = (sel == 2) ? cls2   : cls1;

    // Per-operation monitor record
    int            cyc, rd_n, wr_n, din_bad;
    bit            timed_out;
    logic [AW-1:0] rd_addr [0:63];
    logic [AW-1:0] wr_addr [0:63];

    function automatic logic [DW-1:0] vw(input bit v, input logic [2:0] c, input logic [33:0] j);
        return {v, j, c};
    endfunction

    function automatic logic [DW-1:0] peek(input logic [AW-1:0] a);
        return (sel == 2) ? mem2[a] : mem1[a];
    endfunction

    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic sample_bus();
        if (m_enb === 1'b1 && m_web === 1'b0) begin
            if (rd_n < 64) rd_addr[rd_n] = m_addr;
            rd_n++;
        end else if (m_enb === 1'b1 && m_web === 1'b1) begin
            if (wr_n < 64) wr_addr[wr_n] = m_addr;
            wr_n++;
            if (m_din !== '0) din_bad++;
        end
    endtask

    // Pulse start, then watch the BRAM port until result_valid (bounded).
    task automatic run_op(input logic [AW-1:0] b, input logic [AW-1:0] n, input int budget);
        rd_n = 0; wr_n = 0; din_bad = 0;
        @(negedge clk);
        start_s = 1'b1; base_s = b; num_s = n;
        @(negedge clk);
        start_s = 1'b0;
        cyc = 1;
        sample_bus();
        while (m_valid !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            sample_bus();
        end
        timed_out = (m_valid !== 1'b1);
    endtask

    task automatic ack();
        ready_s = 1'b1;
        @(negedge clk);
        ready_s = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sel = 1;
        checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy1); end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid1); end
        checks++; if (enb1 !== 1'b0 || web1 !== 1'b0) begin errors++; $display("FAIL reset_en: got enb=%0b web=%0b expected 0 0", enb1, web1); end
        checks++; if (addr1 !== 14'h0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", addr1); end
        checks++; if (cls1 !== 3'd0 || votes1 !== 14'd0) begin errors++; $display("FAIL reset_result: got cls=%0d votes=%0d expected 0 0", cls1, votes1); end
        checks++; if (busy2 !== 1'b0 || enb2 !== 1'b0) begin errors++; $display("FAIL reset_dut2: got busy=%0b enb=%0b expected 0 0", busy2, enb2); end
    endtask

    task automatic test_basic();
        logic [2:0] cl [5] = '{3'd2, 3'd2, 3'd1, 3'd2, 3'd3};
        sel = 1;
        for (int i = 0; i < 5; i++) load_word(AW'(i), vw(1'b1, cl[i], 34'h1234 + 34'(i)));
        run_op(14'h0000, 14'd5, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got no result_valid expected valid within 200 cycles"); end
        checks++; if (cyc != 20) begin errors++; $display("FAIL basic_latency: got %0d expected 20", cyc); end
        checks++; if (m_cls !== 3'd2) begin errors++; $display("FAIL basic_class: got %0d expected 2", m_cls); end
        checks++; if (m_votes !== 14'd3) begin errors++; $display("FAIL basic_votes: got %0d expected 3", m_votes); end
        checks++; if (rd_n != 5 || wr_n != 5) begin errors++; $display("FAIL basic_access: got rd=%0d wr=%0d expected 5 5", rd_n, wr_n); end
        checks++; if (din_bad != 0) begin errors++; $display("FAIL basic_dinb: got %0d nonzero writes expected 0", din_bad); end
        for (int i = 0; i < 5 && i < rd_n; i++) begin
            checks++; if (rd_addr[i] !== AW'(i)) begin errors++; $display("FAIL basic_rd_addr%0d: got %0h expected %0h", i, rd_addr[i], i); end
        end
        ack();
        checks++; if (m_valid !== 1'b0 || m_busy !== 1'b0) begin errors++; $display("FAIL basic_handshake: got valid=%0b busy=%0b expected 0 0", m_valid, m_busy); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (peek(AW'(i)) !== '0) begin errors++; $display("FAIL basic_cleared%0d: got %0h expected 0", i, peek(AW'(i))); end
        end
    endtask

    task automatic test_zero();
        sel = 1;
        run_op(14'h0007, 14'd0, 50);
        checks++; if (timed_out || cyc != 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", cyc); end
        checks++; if (m_cls !== 3'd0 || m_votes !== 14'd0) begin errors++; $display("FAIL zero_result: got cls=%0d votes=%0d expected 0 0", m_cls, m_votes); end
        checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %0b expected 1", m_busy); end
        repeat (3) begin
            @(negedge clk);
            sample_bus();
        end
        checks++; if (rd_n != 0 || wr_n != 0) begin errors++; $display("FAIL zero_access: got rd=%0d wr=%0d expected 0 0", rd_n, wr_n); end
        ack();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        logic [2:0]    cl [4] = '{3'd5, 3'd5, 3'd5, 3'd0};
        sel = 1;
        for (int i = 0; i < 4; i++) load_word(ea[i], vw(1'b1, cl[i], 34'h3_0000_0000));
        run_op(14'h3FFE, 14'd4, 200);
        checks++; if (timed_out || cyc != 18) begin errors++; $display("FAIL wrap_latency: got %0d expected 18", cyc); end
        checks++; if (m_cls !== 3'd5 || m_votes !== 14'd3) begin errors++; $display("FAIL wrap_result: got cls=%0d votes=%0d expected 5 3", m_cls, m_votes); end
        checks++; if (rd_n != 4 || wr_n != 4) begin errors++; $display("FAIL wrap_access: got rd=%0d wr=%0d expected 4 4", rd_n, wr_n); end
        for (int i = 0; i < 4 && i < rd_n && i < wr_n; i++) begin
            checks++; if (rd_addr[i] !== ea[i]) begin errors++; $display("FAIL wrap_rd_addr%0d: got %0h expected %0h", i, rd_addr[i], ea[i]); end
            checks++; if (wr_addr[i] !== ea[i]) begin errors++; $display("FAIL wrap_wr_addr%0d: got %0h expected %0h", i, wr_addr[i], ea[i]); end
        end
        ack();
    endtask

    task automatic test_tie();
        logic [DW-1:0] w [6];
        sel = 1;
        w[0] = vw(1'b1, 3'd4, 34'h0);
        w[1] = vw(1'b1, 3'd1, 34'h5);
        w[2] = vw(1'b1, 3'd4, 34'h0);
        w[3] = vw(1'b1, 3'd1, 34'h2_AAAA_AAAA);
        w[4] = vw(1'b0, 3'd4, 34'h3_FFFF_FFFF);
        w[5] = vw(1'b0, 3'd4, 34'h1_5555_5555);
        for (int i = 0; i < 6; i++) load_word(14'h0100 + AW'(i), w[i]);
        run_op(14'h0100, 14'd6, 200);
        checks++; if (timed_out || cyc != 22) begin errors++; $display("FAIL tie_latency: got %0d expected 22", cyc); end
        checks++; if (m_cls !== 3'd1) begin errors++; $display("FAIL tie_class: got %0d expected 1", m_cls); end
        checks++; if (m_votes !== 14'd2) begin errors++; $display("FAIL tie_votes: got %0d expected 2", m_votes); end
        ack();
    endtask

    task automatic test_reset_mid();
        sel = 1;
        for (int i = 0; i < 6; i++) load_word(14'h0200 + AW'(i), vw(1'b1, 3'd7, 34'h0));
        load_word(14'h0300, vw(1'b1, 3'd6, 34'h0));
        load_word(14'h0301, vw(1'b1, 3'd3, 34'h0));
        load_word(14'h0302, vw(1'b1, 3'd6, 34'h0));
        @(negedge clk);
        start_s = 1'b1; base_s = 14'h0200; num_s = 14'd6;
        @(negedge clk);
        start_s = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (m_enb !== 1'b1 || m_busy !== 1'b1) begin errors++; $display("FAIL rstmid_in_read: got enb=%0b busy=%0b expected 1 1", m_enb, m_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (m_busy !== 1'b0 || m_enb !== 1'b0) begin errors++; $display("FAIL rstmid_after: got busy=%0b enb=%0b expected 0 0", m_busy, m_enb); end
        run_op(14'h0300, 14'd3, 200);
        checks++; if (timed_out || cyc != 16) begin errors++; $display("FAIL rstmid_latency: got %0d expected 16", cyc); end
        checks++; if (m_cls !== 3'd6 || m_votes !== 14'd2) begin errors++; $display("FAIL rstmid_result: got cls=%0d votes=%0d expected 6 2", m_cls, m_votes); end
        ack();
    endtask

    task automatic test_rdlat2();
        logic [2:0] cl [5] = '{3'd3, 3'd0, 3'd3, 3'd0, 3'd0};
        sel = 2;
        for (int i = 0; i < 5; i++) load_word(14'h0010 + AW'(i), vw(1'b1, cl[i], 34'h7));
        run_op(14'h0010, 14'd5, 200);
        checks++; if (timed_out || cyc != 21) begin errors++; $display("FAIL lat2_latency: got %0d expected 21", cyc); end
        checks++; if (m_cls !== 3'd0 || m_votes !== 14'd3) begin errors++; $display("FAIL lat2_result: got cls=%0d votes=%0d expected 0 3", m_cls, m_votes); end
        checks++; if (rd_n != 5 || wr_n != 5) begin errors++; $display("FAIL lat2_access: got rd=%0d wr=%0d expected 5 5", rd_n, wr_n); end
        for (int k = 0; k < 10; k++) begin
            start_s = (k == 2);
            base_s = 14'h0000; num_s = 14'd1;
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_cls !== 3'd0 || m_votes !== 14'd3 || m_busy !== 1'b1 || m_enb !== 1'b0) begin
                errors++;
                $display("FAIL lat2_hold%0d: got valid=%0b cls=%0d votes=%0d busy=%0b enb=%0b expected 1 0 3 1 0", k, m_valid, m_cls, m_votes, m_busy, m_enb);
            end
        end
        start_s = 1'b0;
        ack();
        for (int k = 0; k < 3; k++) begin
            checks++; if (m_busy !== 1'b0 || m_enb !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL lat2_idle%0d: got busy=%0b enb=%0b valid=%0b expected 0 0 0", k, m_busy, m_enb, m_valid); end
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (peek(14'h0010 + AW'(i)) !== '0) begin errors++; $display("FAIL lat2_cleared%0d: got %0h expected 0", i, peek(14'h0010 + AW'(i))); end
        end
    endtask

    initial begin
        sel = 1; rst = 1'b1; start_s = 1'b0; ready_s = 1'b0;
        base_s = '0; num_s = '0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        test_reset();
        test_basic();
        test_zero();
        test_wrap();
        test_tie();
        test_reset_mid();
        test_rdlat2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
